order_manager: RTL and testbench

ORDER_MANAGER -- requirements
Module: order_manager

---
 rtl/order_manager.sv | 185 ++++++++++++++++++
 tb/tb_order_manager.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_manager.sv
// order_manager: turns buy/sell decisions into one-at-a-time orders with limits.
// Optional ORDER_STATS_EN adds saturating accepted/dropped order counters.
module order_manager #(
  parameter int data_width = 8,
  parameter int ORDER_QTY  = 10,
  parameter int POS_LIMIT  = 100,
  parameter int COOLDOWN   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  signal_valid,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [data_width-1:0] price_in,
  output logic                  order_valid,
  input  logic                  order_ready,
  output logic                  order_side,
  output logic [15:0]           order_qty,
  output logic [data_width-1:0] order_price,
  output logic [15:0]           position,
  output logic                  busy
`ifdef ORDER_STATS_EN
  ,
  output logic [15:0]           accepted_count,
  output logic [15:0]           dropped_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COOL
  } state_t;

  localparam logic signed [16:0] QTY_S = 17'(ORDER_QTY);
  localparam logic signed [16:0] LIM_S = 17'(POS_LIMIT);
  localparam logic signed [16:0] NLIM_S = -LIM_S;
  localparam logic [15:0] QTY16 = 16'(ORDER_QTY);
  localparam logic [15:0] CD_LOAD =
    16'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);

  state_t                  state_q, state_d;
  logic                    side_q, side_d;
  logic [data_width-1:0]   price_q, price_d;
  logic [15:0]             qty_q, qty_d;
  logic [15:0]             pos_q, pos_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    arm_q, arm_d;

  logic signed [16:0]      pos_ext;
  logic signed [16:0]      buy_sum;
  logic signed [16:0]      sell_sum;
  logic                    buy_ok;
  logic                    sell_ok;
  logic                    one_hot;
  logic                    limit_ok;
  logic                    decision;
  logic                    accept;
  logic                    hs;

  // Limit check in 17-bit signed arithmetic so the sums never wrap.
  always_comb begin
    pos_ext  = {pos_q[15], pos_q};
    buy_sum  = pos_ext + QTY_S;
    sell_sum = pos_ext - QTY_S;
    buy_ok   = (buy_sum <= LIM_S);
    sell_ok  = (sell_sum >= NLIM_S);
    one_hot  = buy_signal ^ sell_signal;
    limit_ok = buy_signal ? buy_ok : sell_ok;
    decision = signal_valid & (buy_signal | sell_signal);
    accept   = (state_q == IDLE) & arm_q & enable
             & signal_valid & one_hot & limit_ok;
    hs       = (state_q == ISSUE) & order_ready;
  end

  // Next-state logic: accept in IDLE, hold in ISSUE, count down in COOL.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    price_d = price_q;
    qty_d   = qty_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    arm_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          side_d  = buy_signal;
          price_d = price_in;
          qty_d   = QTY16;
        end
      end
      ISSUE: begin
        if (hs) begin
          pos_d = side_q ? (pos_q + QTY16)
                         : (pos_q - QTY16);
          if (COOLDOWN == 0) begin
            state_d = IDLE;
          end else begin
            state_d = COOL;
            cnt_d   = CD_LOAD;
          end
        end
      end
      COOL: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; arm_q delays acceptance after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      price_q <= '0;
      qty_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      price_q <= price_d;
      qty_q   <= qty_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    order_valid = (state_q == ISSUE);
    busy        = (state_q != IDLE);
    order_side  = side_q;
    order_qty   = qty_q;
    order_price = price_q;
    position    = pos_q;
  end

`ifdef ORDER_STATS_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] drop_q, drop_d;

  // Saturating counters of handshakes and dropped decisions.
  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (hs && (acc_q != 16'hFFFF)) begin
      acc_d = acc_q + 16'd1;
    end
    if (decision && !accept && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign accepted_count = acc_q;
  assign dropped_count  = drop_q;
`else
  logic unused_decision;
  assign unused_decision = decision;
`endif

endmodule

// File: tb/tb_order_manager.sv
// tb_order_manager: directed checks of order_manager.
// Second instance covers the zero-cooldown build.
module tb_order_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        signal_valid;
  logic        buy_signal;
  logic        sell_signal;
  logic [7:0]  price_in;
  logic        order_ready;
  logic        order_valid;
  logic        order_side;
  logic [15:0] order_qty;
  logic [7:0]  order_price;
  logic [15:0] position;
  logic        busy;
`ifdef ORDER_STATS_EN
  logic [15:0] accepted_count;
  logic [15:0] dropped_count;
  logic [15:0] b_acc;
  logic [15:0] b_drop;
`endif

  logic        b_en;
  logic        b_sv;
  logic        b_buy;
  logic        b_sell;
  logic [7:0]  b_price;
  logic        b_ready;
  logic        b_valid;
  logic        b_side;
  logic [15:0] b_qty;
  logic [7:0]  b_oprice;
  logic [15:0] b_pos;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  order_manager u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .signal_valid (signal_valid),
    .buy_signal   (buy_signal),
    .sell_signal  (sell_signal),
    .price_in     (price_in),
    .order_valid  (order_valid),
    .order_ready  (order_ready),
    .order_side   (order_side),
    .order_qty    (order_qty),
    .order_price  (order_price),
    .position     (position),
    .busy         (busy)
`ifdef ORDER_STATS_EN
    ,
    .accepted_count (accepted_count),
    .dropped_count  (dropped_count)
`endif
  );

  order_manager #(.COOLDOWN(0)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (b_en),
    .signal_valid (b_sv),
    .buy_signal   (b_buy),
    .sell_signal  (b_sell),
    .price_in     (b_price),
    .order_valid  (b_valid),
    .order_ready  (b_ready),
    .order_side   (b_side),
    .order_qty    (b_qty),
    .order_price  (b_oprice),
    .position     (b_pos),
    .busy         (b_busy)
`ifdef ORDER_STATS_EN
    ,
    .accepted_count (b_acc),
    .dropped_count  (b_drop)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    enable       = 1'b1;
    signal_valid = 1'b0;
    buy_signal   = 1'b0;
    sell_signal  = 1'b0;
    price_in     = 8'h00;
    order_ready  = 1'b0;
    b_en         = 1'b0;
    b_sv         = 1'b0;
    b_buy        = 1'b0;
    b_sell       = 1'b0;
    b_price      = 8'h00;
    b_ready      = 1'b0;
  endtask

  task automatic do_reset;
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_in();
    rst_n = 1'b0;
    #1;
    checks++;
    if (order_valid !== 1'b0 || busy !== 1'b0
        || order_side !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl: v=%0b b=%0b s=%0b want 0",
               order_valid, busy, order_side);
    end
    checks++;
    if (order_qty !== 16'd0 || order_price !== 8'd0
        || position !== 16'd0) begin
      errors++;
      $display("FAIL rst_data: q=%0d p=%0h pos=%0d want 0",
               order_qty, order_price, position);
    end
    tick();
    rst_n        = 1'b1;
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    price_in     = 8'h11;
    tick();
    checks++;
    if (order_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_edge: valid=%0b want 0",
               order_valid);
    end
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_price !== 8'h11) begin
      errors++;
      $display("FAIL rst_second_edge: v=%0b p=%0h want 1 11",
               order_valid, order_price);
    end
    idle_in();
    order_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_buy;
    do_reset();
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    price_in     = 8'h40;
    order_ready  = 1'b1;
    tick();
    signal_valid = 1'b0;
    buy_signal   = 1'b0;
    checks++;
    if (order_valid !== 1'b1 || order_side !== 1'b1
        || order_qty !== 16'd10 || order_price !== 8'h40) begin
      errors++;
      $display("FAIL buy_issue: v=%0b s=%0b q=%0d p=%0h want 1 1 10 40",
               order_valid, order_side, order_qty, order_price);
    end
    checks++;
    if (busy !== 1'b1 || position !== 16'd0) begin
      errors++;
      $display("FAIL buy_issue_busy: b=%0b pos=%0d want 1 0",
               busy, position);
    end
    tick();
    checks++;
    if (order_valid !== 1'b0 || position !== 16'd10
        || busy !== 1'b1) begin
      errors++;
      $display("FAIL buy_hs: v=%0b pos=%0d b=%0b want 0 10 1",
               order_valid, position, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL buy_cool%0d: busy=%0b want 1", i, busy);
      end
    end
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    tick();
    signal_valid = 1'b0;
    buy_signal   = 1'b0;
    checks++;
    if (busy !== 1'b0 || order_valid !== 1'b0) begin
      errors++;
      $display("FAIL cool_exit_drop: b=%0b v=%0b want 0 0",
               busy, order_valid);
    end
    tick();
    checks++;
    if (order_valid !== 1'b0 || position !== 16'd10) begin
      errors++;
      $display("FAIL cool_exit_after: v=%0b pos=%0d want 0 10",
               order_valid, position);
    end
  endtask

  task automatic test_stall;
    do_reset();
    order_ready = 1'b1;
    tick();
    checks++;
    if (position !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: pos=%0d b=%0b want 0 0",
               position, busy);
    end
    order_ready  = 1'b0;
    enable       = 1'b0;
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    price_in     = 8'h33;
    tick();
    checks++;
    if (order_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: valid=%0b want 0", order_valid);
    end
    enable   = 1'b1;
    price_in = 8'h55;
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_price !== 8'h55) begin
      errors++;
      $display("FAIL stall_issue: v=%0b p=%0h want 1 55",
               order_valid, order_price);
    end
    buy_signal  = 1'b0;
    sell_signal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      price_in = 8'(i + 1);
      tick();
      checks++;
      if (order_valid !== 1'b1 || order_side !== 1'b1
          || order_price !== 8'h55 || order_qty !== 16'd10
          || position !== 16'd0) begin
        errors++;
        $display("FAIL stall%0d: v=%0b s=%0b p=%0h q=%0d pos=%0d",
                 i, order_valid, order_side, order_price,
                 order_qty, position);
      end
    end
    signal_valid = 1'b0;
    sell_signal  = 1'b0;
    order_ready  = 1'b1;
    tick();
    checks++;
    if (order_valid !== 1'b0 || position !== 16'd10) begin
      errors++;
      $display("FAIL stall_hs: v=%0b pos=%0d want 0 10",
               order_valid, position);
    end
    repeat (4) tick();
    checks++;
    if (position !== 16'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_once: pos=%0d b=%0b want 10 0",
               position, busy);
    end
`ifdef ORDER_STATS_EN
    checks++;
    if (dropped_count !== 16'd6 || accepted_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_stats: drop=%0d acc=%0d want 6 1",
               dropped_count, accepted_count);
    end
`endif
  endtask

  task automatic test_limit;
    do_reset();
    order_ready = 1'b1;
    price_in    = 8'h20;
    for (int i = 0; i < 10; i++) begin
      signal_valid = 1'b1;
      buy_signal   = 1'b1;
      tick();
      signal_valid = 1'b0;
      buy_signal   = 1'b0;
      tick();
      repeat (4) tick();
      checks++;
      if (position !== 16'(10 * (i + 1))) begin
        errors++;
        $display("FAIL limit_buy%0d: pos=%0d want %0d",
                 i, position, 10 * (i + 1));
      end
    end
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    tick();
    signal_valid = 1'b0;
    buy_signal   = 1'b0;
    checks++;
    if (order_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL limit_11th: v=%0b b=%0b want 0 0",
               order_valid, busy);
    end
    tick();
    checks++;
    if (position !== 16'd100) begin
      errors++;
      $display("FAIL limit_hold: pos=%0d want 100", position);
    end
    signal_valid = 1'b1;
    sell_signal  = 1'b1;
    tick();
    signal_valid = 1'b0;
    sell_signal  = 1'b0;
    checks++;
    if (order_valid !== 1'b1 || order_side !== 1'b0) begin
      errors++;
      $display("FAIL limit_sell: v=%0b s=%0b want 1 0",
               order_valid, order_side);
    end
    tick();
    checks++;
    if (position !== 16'd90) begin
      errors++;
      $display("FAIL limit_after_sell: pos=%0d want 90", position);
    end
    repeat (4) tick();
  endtask

  task automatic test_both;
    do_reset();
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    sell_signal  = 1'b1;
    order_ready  = 1'b1;
    tick();
    checks++;
    if (order_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL both: v=%0b b=%0b want 0 0",
               order_valid, busy);
    end
    idle_in();
    tick();
    checks++;
    if (position !== 16'd0 || order_valid !== 1'b0) begin
      errors++;
      $display("FAIL both_pos: pos=%0d v=%0b want 0 0",
               position, order_valid);
    end
  endtask

  task automatic test_reset_issue;
    do_reset();
    signal_valid = 1'b1;
    buy_signal   = 1'b1;
    price_in     = 8'h77;
    tick();
    signal_valid = 1'b0;
    buy_signal   = 1'b0;
    checks++;
    if (order_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_issue_pre: valid=%0b want 1", order_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (order_valid !== 1'b0 || busy !== 1'b0
        || position !== 16'd0) begin
      errors++;
      $display("FAIL rst_issue: v=%0b b=%0b pos=%0d want 0 0 0",
               order_valid, busy, position);
    end
    tick();
    rst_n       = 1'b1;
    order_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (position !== 16'd0 || order_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_issue_post: pos=%0d v=%0b want 0 0",
               position, order_valid);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    b_en    = 1'b1;
    b_sv    = 1'b1;
    b_buy   = 1'b1;
    b_price = 8'h21;
    b_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (b_valid !== ((i % 2) == 0)
          || b_pos !== 16'(10 * ((i + 1) / 2))) begin
        errors++;
        $display("FAIL b2b%0d: v=%0b pos=%0d want %0b %0d",
                 i, b_valid, b_pos, ((i % 2) == 0),
                 10 * ((i + 1) / 2));
      end
    end
    idle_in();
    tick();
  endtask

  initial begin
    test_reset();
    test_buy();
    test_stall();
    test_limit();
    test_both();
    test_reset_issue();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
